led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Purpose: LED pattern sequencer (OFF / ON / BLINK / BURST) driven by a TICK_DIV-cycle prescaler tick.
// Latency: an accepted command sets state and led on the next cycle; led is always a registered output.
// Backpressure: cmd_ready is low while a burst runs; the burst cannot be interrupted except by rst.
// Optional feature: define LED_SEQ_PWM_EN to add the pwm_duty input and PWM dimming of led.
module led_pattern_sequencer #(
   parameter int TICK_DIV = 25000000,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [3:0]       cmd_period,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             busy,
   output logic             done,
`ifdef LED_SEQ_PWM_EN
   input  logic [3:0]       pwm_duty,
`endif
   output logic             led
);

   localparam int            PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_BURST = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_STEADY    = 3'd1,
      S_BLINK     = 3'd2,
      S_BURST_ON  = 3'd3,
      S_BURST_OFF = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PW-1:0]    r_presc;
   logic [3:0]       r_hp_cnt;
   logic [3:0]       r_period;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_pulse_cnt;
   logic [CNT_W-1:0] w_pulse_nxt;
   logic             r_level;
   logic             w_level_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_burst;
   logic             w_ready;
   logic             w_accept;
   logic             w_tick;
   logic [3:0]       w_period_eff;
   logic             w_phase_end;

   // Handshake and timing decodes shared by the counters and the FSM.
   always_comb begin
      w_burst      = (r_state == S_BURST_ON) || (r_state == S_BURST_OFF);
      w_ready      = !w_burst;
      w_accept     = cmd_valid && w_ready;
      w_tick       = (r_presc == TICK_LAST);
      w_period_eff = (r_period == 4'd0) ? 4'd1 : r_period;
      w_phase_end  = w_tick && (r_hp_cnt == (w_period_eff - 4'd1));
   end

   // Prescaler and half-period counter; both restart on acceptance so a new
   // pattern's first phase lasts exactly period*TICK_DIV cycles.
   always_ff @(posedge clk) begin
      if (rst || w_accept) begin
         r_presc  <= '0;
         r_hp_cnt <= 4'd0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_phase_end) begin
            r_hp_cnt <= 4'd0;
         end else if (w_tick) begin
            r_hp_cnt <= r_hp_cnt + 4'd1;
         end
      end
   end

   // Capture command fields on acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_period <= 4'd0;
         r_count  <= '0;
      end else if (w_accept) begin
         r_period <= cmd_period;
         r_count  <= cmd_count;
      end
   end

   // FSM state register together with pattern level, done pulse and pulse counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_level     <= 1'b0;
         r_done      <= 1'b0;
         r_pulse_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_level     <= w_level_nxt;
         r_done      <= w_done_nxt;
         r_pulse_cnt <= w_pulse_nxt;
      end
   end

   // Next-state logic: an accepted command always wins over a coincident tick.
   always_comb begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      w_done_nxt  = 1'b0;
      w_pulse_nxt = r_pulse_cnt;
      if (w_accept) begin
         case (cmd_mode)
            MODE_OFF: begin
               w_state_nxt = S_IDLE;
               w_level_nxt = 1'b0;
            end
            MODE_ON: begin
               w_state_nxt = S_STEADY;
               w_level_nxt = 1'b1;
            end
            MODE_BLINK: begin
               w_state_nxt = S_BLINK;
               w_level_nxt = 1'b1;
            end
            MODE_BURST: begin
               w_pulse_nxt = '0;
               if (cmd_count == '0) begin
                  // Empty burst completes immediately.
                  w_state_nxt = S_IDLE;
                  w_level_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_BURST_ON;
                  w_level_nxt = 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_level_nxt = 1'b0;
            end
         endcase
      end else if (w_phase_end) begin
         case (r_state)
            S_BLINK: begin
               w_level_nxt = !r_level;
            end
            S_BURST_ON: begin
               // Pulse counter counts completed high phases; it peaks at r_count and never wraps.
               w_state_nxt = S_BURST_OFF;
               w_level_nxt = 1'b0;
               w_pulse_nxt = r_pulse_cnt + 1'b1;
            end
            S_BURST_OFF: begin
               if (r_pulse_cnt < r_count) begin
                  w_state_nxt = S_BURST_ON;
                  w_level_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_level_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
               end
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   assign cmd_ready = w_ready;
   assign busy      = w_burst;
   assign done      = r_done;

`ifdef LED_SEQ_PWM_EN
   logic [3:0] r_pwm_cnt;
   logic       r_led;

   // Free-running PWM counter gates the next pattern level into the led register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwm_cnt <= 4'd0;
         r_led     <= 1'b0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 4'd1;
         r_led     <= w_level_nxt && (r_pwm_cnt < pwm_duty);
      end
   end

   assign led = r_led;
`else
   assign led = r_level;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Purpose: self-checking bench for led_pattern_sequencer against an arithmetic pattern model.
// Latency: every cycle's led/busy/done/cmd_ready is compared at the falling edge.
// Backpressure: the model decides acceptance from its own expected cmd_ready.
module tb_led_pattern_sequencer;

   localparam int TD    = 4;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_mode;
   logic [3:0]       cmd_period;
   logic [CNT_W-1:0] cmd_count;
   logic             busy;
   logic             done;
   logic             led;
`ifdef LED_SEQ_PWM_EN
   logic [3:0]       pwm_duty;
`endif

   led_pattern_sequencer #(.TICK_DIV(TD), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_period (cmd_period),
      .cmd_count  (cmd_count),
      .busy       (busy),
      .done       (done),
`ifdef LED_SEQ_PWM_EN
      .pwm_duty   (pwm_duty),
`endif
      .led        (led)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Model: the last pattern that took effect, and the cycle it took effect on.
   int m_mode = 0;
   int m_p    = 1;
   int m_n    = 0;
   int m_t0   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Expected outputs for cycle c, from elapsed time since the pattern started.
   task automatic model_out(input int c, output logic e_led, output logic e_busy,
                            output logic e_done, output logic e_rdy);
      int k;
      int ph;
      int len;
      k      = c - m_t0;
      ph     = ((m_p == 0) ? 1 : m_p) * TD;
      e_led  = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_rdy  = 1'b1;
      case (m_mode)
         1: e_led = 1'b1;
         2: e_led = ((k / ph) % 2) == 0;
         3: begin
            len = m_n * 2 * ph;
            if (k < len) begin
               e_busy = 1'b1;
               e_rdy  = 1'b0;
               e_led  = ((k / ph) % 2) == 0;
            end else begin
               e_done = (k == len);
            end
         end
         default: e_led = 1'b0;
      endcase
   endtask

   task automatic check_all();
      logic el, eb, ed, er;
      model_out(cyc, el, eb, ed, er);
`ifndef LED_SEQ_PWM_EN
      chk("led", {31'd0, led}, {31'd0, el});
`endif
      chk("busy", {31'd0, busy}, {31'd0, eb});
      chk("done", {31'd0, done}, {31'd0, ed});
      chk("ready", {31'd0, cmd_ready}, {31'd0, er});
   endtask

   // Drive one cycle of inputs (called at a falling edge), advance the model, check.
   task automatic step(input logic v, input logic [1:0] md, input logic [3:0] pd,
                       input logic [CNT_W-1:0] ct, input logic r);
      logic el, eb, ed, er;
      model_out(cyc, el, eb, ed, er);
      rst        = r;
      cmd_valid  = v;
      cmd_mode   = md;
      cmd_period = pd;
      cmd_count  = ct;
      @(posedge clk);
      cyc++;
      if (r) begin
         m_mode = 0;
         m_t0   = cyc;
      end else if (v && er) begin
         m_mode = int'(md);
         m_p    = int'(pd);
         m_n    = int'(ct);
         m_t0   = cyc;
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'd0, '0, 1'b0);
   endtask

   initial begin
      // Reset held 3 cycles with a command presented the whole time.
      rst        = 1'b1;
      cmd_valid  = 1'b1;
      cmd_mode   = 2'd1;
      cmd_period = 4'd1;
      cmd_count  = 8'd3;
`ifdef LED_SEQ_PWM_EN
      pwm_duty   = 4'd15;
`endif
      @(posedge clk);
      m_mode = 0;
      m_t0   = 0;
      @(negedge clk);
      check_all();
      step(1'b1, 2'd1, 4'd1, 8'd3, 1'b1);
      step(1'b1, 2'd3, 4'd1, 8'd3, 1'b1);
      idle(3);

      // ON, then OFF ten cycles later.
      step(1'b1, 2'd1, 4'd0, '0, 1'b0);
      idle(9);
      step(1'b1, 2'd0, 4'd0, '0, 1'b0);
      idle(3);

      // BLINK with period 2, then period 0 (treated as 1).
      step(1'b1, 2'd2, 4'd2, '0, 1'b0);
      idle(40);
      step(1'b1, 2'd2, 4'd0, '0, 1'b0);
      idle(20);

      // BURST of 3 with a command held valid throughout; it is taken only after done.
      step(1'b1, 2'd3, 4'd1, 8'd3, 1'b0);
      for (int i = 0; i < 30; i++) step(1'b1, 2'd1, 4'd0, '0, 1'b0);
      step(1'b1, 2'd0, 4'd0, '0, 1'b0);

      // Empty burst pulses done on the next cycle.
      step(1'b1, 2'd3, 4'd3, 8'd0, 1'b0);
      idle(4);

      // Reset during the second pulse of a 5-pulse burst aborts with no done.
      step(1'b1, 2'd3, 4'd1, 8'd5, 1'b0);
      idle(9);
      step(1'b0, 2'd0, 4'd0, '0, 1'b1);
      idle(50);

      // Largest burst count: exactly 255 pulses and no wrap.
      step(1'b1, 2'd3, 4'd1, 8'd255, 1'b0);
      idle(255 * 8 + 4);

`ifdef LED_SEQ_PWM_EN
      begin
         int hi;
         pwm_duty = 4'd8;
         step(1'b1, 2'd1, 4'd0, '0, 1'b0);
         idle(16);
         hi = 0;
         for (int i = 0; i < 16; i++) begin
            step(1'b0, 2'd0, 4'd0, '0, 1'b0);
            if (led) hi++;
         end
         chk("pwm_duty8", hi, 8);
         pwm_duty = 4'd0;
         idle(2);
         hi = 0;
         for (int i = 0; i < 16; i++) begin
            step(1'b0, 2'd0, 4'd0, '0, 1'b0);
            if (led) hi++;
         end
         chk("pwm_duty0", hi, 0);
         pwm_duty = 4'd15;
      end
`endif

      // Randomized traffic, with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         logic             v, r;
         logic [1:0]       md;
         logic [3:0]       pd;
         logic [CNT_W-1:0] ct;
         v  = ($urandom_range(0, 7) == 0);
         r  = ($urandom_range(0, 399) == 0);
         md = 2'($urandom_range(0, 3));
         pd = 4'($urandom_range(0, 3));
         ct = CNT_W'($urandom_range(0, 4));
         step(v, md, pd, ct, r);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
